// File: rtl/mccoy_pkg.sv
// Shared definitions for the McCoy control path: opcodes, ALU and x8 source
// encodings, the decoded control word and the sequencer state type.
package mccoy_pkg;

    localparam logic [3:0] OP_LI  = 4'd0;
    localparam logic [3:0] OP_JA  = 4'd1;
    localparam logic [3:0] OP_BEZ = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_LR  = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_NOT = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] X8_REG = 2'd0;
    localparam logic [1:0] X8_IMM = 2'd1;
    localparam logic [1:0] X8_ALU = 2'd2;

    // alu_fun is carried at its widest; the top trims it to ALU_W
    typedef struct packed {
        logic       bez;
        logic       ja;
        logic       op1;
        logic [1:0] op2;
        logic [1:0] alu_fun;
        logic       write_reg;
        logic       write_x8;
        logic [1:0] x8_sel;
    } ctl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode decode: control word, illegal flag and memory-phase flag.
module ctrl_decode_rom
    import mccoy_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int ALU_W = 1
) (
    input  logic [OP_W-1:0] opcode,
    output ctl_t            ctl,
    output logic            illegal,
    output logic            is_mem
);

    localparam logic [1:0] ALU_MASK = (ALU_W == 2) ? 2'b11 : 2'b01;

    logic [3:0] op;
    assign op = 4'(opcode);

    always_comb begin
        ctl     = '0;
        illegal = 1'b0;
        is_mem  = 1'b0;
        case (op)
            OP_LI: begin
                ctl.write_x8 = 1'b1;
                ctl.x8_sel   = X8_IMM;
            end
            OP_JA: begin
                ctl.ja  = 1'b1;
                ctl.op1 = 1'b1;
                ctl.op2 = 2'd1;
            end
            OP_BEZ: begin
                ctl.bez = 1'b1;
                ctl.op2 = 2'd1;
            end
            OP_ADD, OP_NOT: begin
                ctl.op1      = 1'b1;
                ctl.alu_fun  = (op == OP_NOT) ? ALU_NOT : ALU_ADD;
                ctl.write_x8 = 1'b1;
                ctl.x8_sel   = X8_ALU;
            end
            OP_LR: begin
                ctl.write_x8 = 1'b1;
                ctl.x8_sel   = X8_REG;
                is_mem       = 1'b1;
            end
            OP_SR: begin
                ctl.write_reg = 1'b1;
                is_mem        = 1'b1;
            end
            // and/or exist only in the wide encoding; with 3-bit opcodes 7 is illegal
            OP_AND, OP_OR: begin
                if (OP_W == 4) begin
                    ctl.op1      = 1'b1;
                    ctl.alu_fun  = (op == OP_AND) ? ALU_AND : ALU_OR;
                    ctl.write_x8 = 1'b1;
                    ctl.x8_sel   = X8_ALU;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        ctl.alu_fun = ctl.alu_fun & ALU_MASK;
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered, handshaked control unit: accepts opcodes, runs lr/sr through a
// timed memory phase and holds the decoded word until execute consumes it.
//
//   state    | meaning
//   ST_IDLE  | no word held, ready for an opcode
//   ST_MEM   | lr/sr waiting for mem_ack, timeout counter running
//   ST_ISSUE | control word valid, waiting for ctl_ready
module ctrl_sequencer
    import mccoy_pkg::*;
#(
    parameter int OP_W   = 3,
    parameter int ALU_W  = 1,
    parameter int MEM_TO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    output logic             ctl_valid,
    input  logic             ctl_ready,
    output logic             bez,
    output logic             ja,
    output logic             op1,
    output logic             write_reg,
    output logic             write_x8,
    output logic [ALU_W-1:0] alu_fun,
    output logic [1:0]       op2,
    output logic [1:0]       x8_sel,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic             illegal,
    output logic             mem_fault,
    output logic             busy
);

    state_t     state;
    ctl_t       ctl_q;
    ctl_t       word_q;
    logic [7:0] cnt;
    ctl_t       dec_ctl;
    logic       dec_illegal;
    logic       dec_mem;
    logic       accept;

    ctrl_decode_rom #(.OP_W(OP_W), .ALU_W(ALU_W)) u_rom (
        .opcode  (opcode),
        .ctl     (dec_ctl),
        .illegal (dec_illegal),
        .is_mem  (dec_mem)
    );

    assign in_ready = (state == ST_IDLE) || (state == ST_ISSUE && ctl_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ctl_q     <= '0;
            word_q    <= '0;
            cnt       <= '0;
            ctl_valid <= 1'b0;
            mem_req   <= 1'b0;
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                ST_IDLE, ST_ISSUE: begin
                    if (accept) begin
                        if (dec_illegal) begin
                            illegal   <= 1'b1;
                            state     <= ST_IDLE;
                            ctl_valid <= 1'b0;
                            ctl_q     <= '0;
                        end else if (dec_mem) begin
                            // word parked until the memory phase completes
                            state     <= ST_MEM;
                            word_q    <= dec_ctl;
                            mem_req   <= 1'b1;
                            cnt       <= '0;
                            ctl_valid <= 1'b0;
                            ctl_q     <= '0;
                        end else begin
                            state     <= ST_ISSUE;
                            ctl_q     <= dec_ctl;
                            ctl_valid <= 1'b1;
                        end
                    end else if (state == ST_IDLE || ctl_ready) begin
                        state     <= ST_IDLE;
                        ctl_valid <= 1'b0;
                        ctl_q     <= '0;
                    end
                end
                ST_MEM: begin
                    // ack is checked first so it wins a same-cycle timeout
                    if (mem_ack) begin
                        state     <= ST_ISSUE;
                        ctl_q     <= word_q;
                        ctl_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt == 8'(MEM_TO - 1)) begin
                        state     <= ST_IDLE;
                        mem_fault <= 1'b1;
                        mem_req   <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ctl_valid <= 1'b0;
                    mem_req   <= 1'b0;
                    ctl_q     <= '0;
                end
            endcase
        end
    end

    assign bez       = ctl_q.bez;
    assign ja        = ctl_q.ja;
    assign op1       = ctl_q.op1;
    assign op2       = ctl_q.op2;
    assign alu_fun   = ctl_q.alu_fun[ALU_W-1:0];
    assign write_reg = ctl_q.write_reg;
    assign write_x8  = ctl_q.write_x8;
    assign x8_sel    = ctl_q.x8_sel;

    logic unused_alu_bits;
    assign unused_alu_bits = ^ctl_q.alu_fun;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a 3-bit instance with a short timeout and
// a 4-bit instance for the wide-opcode decode.
module tb_ctrl_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 3-bit opcode instance, MEM_TO=4
    logic       in_valid = 1'b0, ctl_ready = 1'b0, mem_ack = 1'b0;
    logic [2:0] opcode = '0;
    logic       in_ready, ctl_valid, bez, ja, op1, write_reg, write_x8;
    logic [0:0] alu_fun;
    logic [1:0] op2, x8_sel;
    logic       mem_req, illegal, mem_fault, busy;

    ctrl_sequencer #(.OP_W(3), .ALU_W(1), .MEM_TO(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .ctl_valid(ctl_valid), .ctl_ready(ctl_ready),
        .bez(bez), .ja(ja), .op1(op1), .write_reg(write_reg), .write_x8(write_x8),
        .alu_fun(alu_fun), .op2(op2), .x8_sel(x8_sel), .mem_req(mem_req),
        .mem_ack(mem_ack), .illegal(illegal), .mem_fault(mem_fault), .busy(busy)
    );

    // 4-bit opcode instance
    logic       v4 = 1'b0, r4 = 1'b0, a4 = 1'b0;
    logic [3:0] op4 = '0;
    logic       rdy4, cv4, bez4, ja4, op1_4, wr4, wx4;
    logic [1:0] alu4, op2_4, x8_4;
    logic       mr4, ill4, mf4, busy4;

    ctrl_sequencer #(.OP_W(4), .ALU_W(2), .MEM_TO(15)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4),
        .opcode(op4), .ctl_valid(cv4), .ctl_ready(r4),
        .bez(bez4), .ja(ja4), .op1(op1_4), .write_reg(wr4), .write_x8(wx4),
        .alu_fun(alu4), .op2(op2_4), .x8_sel(x8_4), .mem_req(mr4),
        .mem_ack(a4), .illegal(ill4), .mem_fault(mf4), .busy(busy4)
    );

    // status: {ctl_valid, mem_req, illegal, mem_fault, busy, in_ready}
    logic [5:0]  st3, st4;
    logic [9:0]  cw3;
    logic [10:0] cw4;
    assign st3 = {ctl_valid, mem_req, illegal, mem_fault, busy, in_ready};
    assign cw3 = {bez, ja, op1, op2, alu_fun, write_reg, write_x8, x8_sel};
    assign st4 = {cv4, mr4, ill4, mf4, busy4, rdy4};
    assign cw4 = {bez4, ja4, op1_4, op2_4, alu4, wr4, wx4, x8_4};

    // control words {bez,ja,op1,op2,alu,write_reg,write_x8,x8_sel}
    localparam logic [9:0] CW_NONE = 10'b0;
    localparam logic [9:0] CW_LI   = 10'b0_0_0_00_0_0_1_01;
    localparam logic [9:0] CW_JA   = 10'b0_1_1_01_0_0_0_00;
    localparam logic [9:0] CW_ADD  = 10'b0_0_1_00_0_0_1_10;
    localparam logic [9:0] CW_LR   = 10'b0_0_0_00_0_0_1_00;
    localparam logic [9:0] CW_NOT  = 10'b0_0_1_00_1_0_1_10;
    localparam logic [9:0] CW_SR   = 10'b0_0_0_00_0_1_0_00;
    localparam logic [10:0] CW4_NONE = 11'b0;
    localparam logic [10:0] CW4_AND  = 11'b0_0_1_00_10_0_1_10;
    localparam logic [10:0] CW4_OR   = 11'b0_0_1_00_11_0_1_10;
    localparam logic [10:0] CW4_NOT  = 11'b0_0_1_00_01_0_1_10;

    localparam logic [5:0] S_IDLE   = 6'b000001;
    localparam logic [5:0] S_ISS_R  = 6'b100011;
    localparam logic [5:0] S_ISS_B  = 6'b100010;
    localparam logic [5:0] S_MEM    = 6'b010010;
    localparam logic [5:0] S_ILL    = 6'b001001;
    localparam logic [5:0] S_FAULT  = 6'b000101;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect3(input string tag, input logic [5:0] est, input logic [9:0] ecw);
        checks++;
        assert (st3 === est) else begin
            errors++;
            $error("FAIL %s status: observed=%b expected=%b", tag, st3, est);
        end
        checks++;
        assert (cw3 === ecw) else begin
            errors++;
            $error("FAIL %s ctl: observed=%b expected=%b", tag, cw3, ecw);
        end
    endtask

    task automatic expect4(input string tag, input logic [5:0] est, input logic [10:0] ecw);
        checks++;
        assert (st4 === est) else begin
            errors++;
            $error("FAIL %s status: observed=%b expected=%b", tag, st4, est);
        end
        checks++;
        assert (cw4 === ecw) else begin
            errors++;
            $error("FAIL %s ctl: observed=%b expected=%b", tag, cw4, ecw);
        end
    endtask

    initial begin
        #3;
        expect3("reset", S_IDLE, CW_NONE);
        expect4("reset4", S_IDLE, CW4_NONE);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back issue
        in_valid = 1'b1; opcode = 3'd3; ctl_ready = 1'b1;
        tick(); expect3("b2b_add", S_ISS_R, CW_ADD);
        opcode = 3'd5;
        tick(); expect3("b2b_not", S_ISS_R, CW_NOT);
        opcode = 3'd1;
        tick(); expect3("b2b_ja", S_ISS_R, CW_JA);
        in_valid = 1'b0;
        tick(); expect3("b2b_idle", S_IDLE, CW_NONE);

        // backpressure: changing opcode while blocked must be ignored
        ctl_ready = 1'b0; in_valid = 1'b1; opcode = 3'd0;
        tick(); expect3("bp_0", S_ISS_B, CW_LI);
        opcode = 3'd3;
        for (int i = 1; i < 4; i++) begin
            tick(); expect3("bp_hold", S_ISS_B, CW_LI);
        end
        in_valid = 1'b0; ctl_ready = 1'b1;
        tick(); expect3("bp_release", S_IDLE, CW_NONE);
        ctl_ready = 1'b0;

        // sr with ack in the third memory cycle
        in_valid = 1'b1; opcode = 3'd6;
        tick(); expect3("sr_mem1", S_MEM, CW_NONE);
        in_valid = 1'b0;
        tick(); expect3("sr_mem2", S_MEM, CW_NONE);
        tick(); expect3("sr_mem3", S_MEM, CW_NONE);
        mem_ack = 1'b1;
        tick(); expect3("sr_issue", S_ISS_B, CW_SR);
        mem_ack = 1'b0; ctl_ready = 1'b1;
        tick(); expect3("sr_done", S_IDLE, CW_NONE);
        ctl_ready = 1'b0;

        // lr timeout with MEM_TO=4
        in_valid = 1'b1; opcode = 3'd4;
        tick(); expect3("to_mem1", S_MEM, CW_NONE);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick(); expect3("to_mem", S_MEM, CW_NONE);
        end
        tick(); expect3("to_fault", S_FAULT, CW_NONE);
        tick(); expect3("to_after", S_IDLE, CW_NONE);

        // ack on the timeout cycle wins
        in_valid = 1'b1; opcode = 3'd4;
        tick(); expect3("race_mem1", S_MEM, CW_NONE);
        in_valid = 1'b0;
        tick(); tick(); tick(); expect3("race_mem4", S_MEM, CW_NONE);
        mem_ack = 1'b1;
        tick(); expect3("race_issue", S_ISS_B, CW_LR);
        ctl_ready = 1'b1;
        tick(); expect3("race_idle_ack_ignored", S_IDLE, CW_NONE);
        mem_ack = 1'b0;
        tick(); expect3("race_quiet", S_IDLE, CW_NONE);

        // illegal from IDLE and from ISSUE
        in_valid = 1'b1; opcode = 3'd7;
        tick(); expect3("ill_idle", S_ILL, CW_NONE);
        in_valid = 1'b0;
        tick(); expect3("ill_pulse_end", S_IDLE, CW_NONE);
        in_valid = 1'b1; opcode = 3'd3;
        tick(); expect3("ill_pre", S_ISS_R, CW_ADD);
        opcode = 3'd7;
        tick(); expect3("ill_issue", S_ILL, CW_NONE);

        // ISSUE straight into MEM, then ack
        opcode = 3'd3;
        tick(); expect3("im_add", S_ISS_R, CW_ADD);
        opcode = 3'd6;
        tick(); expect3("im_mem", S_MEM, CW_NONE);
        in_valid = 1'b0; mem_ack = 1'b1;
        tick(); expect3("im_issue", S_ISS_R, CW_SR);
        mem_ack = 1'b0;
        tick(); expect3("im_idle", S_IDLE, CW_NONE);
        ctl_ready = 1'b0;

        // asynchronous reset in the middle of a memory phase
        in_valid = 1'b1; opcode = 3'd6;
        tick(); in_valid = 1'b0;
        tick(); expect3("rst_pre", S_MEM, CW_NONE);
        rst = 1'b1;
        #1; expect3("rst_async", S_IDLE, CW_NONE);
        @(negedge clk);
        rst = 1'b0;
        tick(); expect3("rst_after1", S_IDLE, CW_NONE);
        tick(); expect3("rst_after2", S_IDLE, CW_NONE);

        // wide-opcode decode
        v4 = 1'b1; op4 = 4'd7; r4 = 1'b1;
        tick(); expect4("w_and", S_ISS_R, CW4_AND);
        op4 = 4'd8;
        tick(); expect4("w_or", S_ISS_R, CW4_OR);
        op4 = 4'd5;
        tick(); expect4("w_not", S_ISS_R, CW4_NOT);
        op4 = 4'd12;
        tick(); expect4("w_ill12", S_ILL, CW4_NONE);
        op4 = 4'd9;
        tick(); expect4("w_ill9", S_ILL, CW4_NONE);
        op4 = 4'd15;
        tick(); expect4("w_ill15", S_ILL, CW4_NONE);
        v4 = 1'b0;
        tick(); expect4("w_idle", S_IDLE, CW4_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
